// File: rtl/i2s_serializer.sv
// i2s_serializer: serial audio output stage in the mclk domain.
// Holds one stereo sample pair in a single-entry buffer. Each pair is sent
// as a 64-bit I2S frame, with a one-bit delay after every ws edge. req_out
// pulses for one cycle whenever a new frame is loaded.
// Ports:
//   clk, rst_n           master clock, asynchronous active-low reset
//   play_in              playback enable (already synchronized to clk)
//   tick_in              strobe qualifying audio0_in / audio1_in
//   audio0_in/audio1_in  left / right samples, two's complement
//   req_out              one-cycle request for the next sample pair
//   sck_out              bit clock, clk / SCK_DIV
//   ws_out               word select (0 = left, 1 = right)
//   sdo_out              serial data, MSB first
module i2s_serializer #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned SCK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  play_in,
  input  logic                  tick_in,
  input  logic [DATA_WIDTH-1:0] audio0_in,
  input  logic [DATA_WIDTH-1:0] audio1_in,
  output logic                  req_out,
  output logic                  sck_out,
  output logic                  ws_out,
  output logic                  sdo_out
);

  localparam int unsigned DIV_W   = (SCK_DIV > 2) ? $clog2(SCK_DIV) : 1;
  localparam int unsigned BUF_W   = 2 * DATA_WIDTH;
  localparam int unsigned PAD     = 31 - DATA_WIDTH;
  localparam int unsigned FRAME_W = 64;
  localparam int unsigned CNT_W   = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_STOP = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [DIV_W-1:0]     r_div;
  logic [CNT_W-1:0]     r_bitcnt;
  logic [FRAME_W-1:0]   r_shift;
  logic [BUF_W-1:0]     r_buf;
  logic                 r_valid;
  logic                 r_req;
  logic                 r_sck;
  logic                 r_ws;

  logic                 w_adv;
  logic                 w_wrap;
  logic                 w_load;
  logic                 w_stop_end;
  logic                 w_wr;
  logic [31:0]          w_half_l;
  logic [31:0]          w_half_r;
  logic [FRAME_W-1:0]   w_frame;
  logic [DIV_W-1:0]     w_div_nxt;
  logic [CNT_W-1:0]     w_bit_nxt;
  logic [FRAME_W-1:0]   w_shift_nxt;
  logic [BUF_W-1:0]     w_buf_nxt;
  logic                 w_valid_nxt;

  // Bit advance on the sck falling edge; wrap when bit 63 completes.
  assign w_adv      = (r_state != S_IDLE) && (r_div == DIV_W'(SCK_DIV - 1));
  assign w_wrap     = w_adv && (r_bitcnt == CNT_W'(63));
  // A STOPPING frame that wraps while play_in is back high continues seamlessly.
  assign w_load     = ((r_state == S_IDLE) && play_in) ||
                      (w_wrap && ((r_state == S_PLAY) || play_in));
  assign w_stop_end = w_wrap && (r_state == S_STOP) && !play_in;
  assign w_wr       = (r_state != S_IDLE) && play_in && tick_in;

  // Each half word: one delay bit, the sample, then zero padding to 32 bits.
  assign w_half_l = 32'({1'b0, r_buf[BUF_W-1:DATA_WIDTH]}) << PAD;
  assign w_half_r = 32'({1'b0, r_buf[DATA_WIDTH-1:0]}) << PAD;
  assign w_frame  = r_valid ? {w_half_l, w_half_r} : '0;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (play_in) w_state_nxt = S_PLAY;
      S_PLAY: if (!play_in) w_state_nxt = S_STOP;
      S_STOP: begin
        if (play_in) begin
          w_state_nxt = S_PLAY;
        end else if (w_wrap) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values for divider, bit counter, shift register and buffer.
  always_comb begin
    w_div_nxt   = r_div;
    w_bit_nxt   = r_bitcnt;
    w_shift_nxt = r_shift;
    w_buf_nxt   = r_buf;
    w_valid_nxt = r_valid;
    if (w_load) begin
      w_div_nxt   = '0;
      w_bit_nxt   = '0;
      w_shift_nxt = w_frame;
      w_valid_nxt = 1'b0;
    end else if (w_stop_end || (r_state == S_IDLE)) begin
      w_div_nxt   = '0;
      w_bit_nxt   = '0;
      w_shift_nxt = '0;
      w_buf_nxt   = '0;
      w_valid_nxt = 1'b0;
    end else if (w_adv) begin
      w_div_nxt   = '0;
      w_bit_nxt   = r_bitcnt + CNT_W'(1);
      w_shift_nxt = {r_shift[FRAME_W-2:0], 1'b0};
    end else begin
      w_div_nxt   = r_div + DIV_W'(1);
    end
    // A tick on a load edge lands after the load, so it feeds the next frame.
    if (w_wr) begin
      w_buf_nxt   = {audio0_in, audio1_in};
      w_valid_nxt = 1'b1;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div    <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_buf    <= '0;
      r_valid  <= 1'b0;
      r_req    <= 1'b0;
      r_sck    <= 1'b0;
      r_ws     <= 1'b0;
    end else begin
      r_div    <= w_div_nxt;
      r_bitcnt <= w_bit_nxt;
      r_shift  <= w_shift_nxt;
      r_buf    <= w_buf_nxt;
      r_valid  <= w_valid_nxt;
      r_req    <= w_load;
      r_sck    <= (w_div_nxt >= DIV_W'(SCK_DIV / 2));
      r_ws     <= w_bit_nxt[CNT_W-1];
    end
  end

  assign req_out = r_req;
  assign sck_out = r_sck;
  assign ws_out  = r_ws;
  assign sdo_out = r_shift[FRAME_W-1];

endmodule
